// File: rtl/keypad_entry32.sv
// Hex keypad entry: scans a 4x4 active-low matrix, debounces presses and shifts
// accepted digits into a 32-bit entry word that is delivered on a commit press.
module keypad_entry32 #(
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  key_col,
    input  logic        commit_btn,
    output logic [3:0]  key_row,
    output logic [31:0] data_bits,
    output logic        data_valid,
    output logic [3:0]  key_code,
    output logic        key_strobe,
    output logic [3:0]  digit_count
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);
    localparam logic [3:0] MAX_DIGITS = 4'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } state_e;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       key_row_q, key_row_d;
    logic [1:0]       acc_n_q, acc_n_d;
    logic [3:0]       acc_code_q, acc_code_d;
    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      entry_q, entry_d;
    logic [3:0]       digit_count_q, digit_count_d;
    logic [31:0]      data_bits_q, data_bits_d;
    logic             data_valid_q, data_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_strobe_q, key_strobe_d;
    logic             commit_prev_q, commit_prev_d;

    logic        sample;
    logic        frame_end;
    logic [2:0]  cur_n;
    logic [1:0]  cur_col;
    logic [2:0]  sum_n;
    logic [1:0]  frame_n;
    logic [3:0]  frame_code;
    logic        frame_single;
    logic        frame_none;
    logic        accept;
    logic        commit_rise;
    logic [31:0] shifted;

    // Row scan and per-frame key accumulation
    always_comb begin
        sample    = (div_q == DIV_LAST);
        frame_end = sample && (row_q == 2'd3);

        cur_n   = 3'd0;
        cur_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!key_col[c]) begin
                cur_n   = cur_n + 3'd1;
                cur_col = 2'(c);
            end
        end

        sum_n      = {1'b0, acc_n_q} + cur_n;
        frame_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        frame_code = (cur_n != 3'd0) ? {row_q, cur_col} : acc_code_q;

        frame_single = frame_end && (frame_n == 2'd1);
        frame_none   = frame_end && (frame_n == 2'd0);

        div_d      = div_q + DIV_W'(1);
        row_d      = row_q;
        acc_n_d    = acc_n_q;
        acc_code_d = acc_code_q;
        if (sample) begin
            div_d = '0;
            row_d = 2'(row_q + 2'd1);
            if (row_q == 2'd3) begin
                acc_n_d    = 2'd0;
                acc_code_d = 4'd0;
            end else begin
                acc_n_d    = frame_n;
                acc_code_d = frame_code;
            end
        end
        key_row_d = ~(4'b0001 << row_d);
    end

    // Debounce FSM, stepped once per frame; MULTI counts as NONE except in HELD
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_single) begin
                        if (DEB == 4'd1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = CAND;
                            cand_d  = frame_code;
                            cnt_d   = 4'd1;
                        end
                    end
                end
                CAND: begin
                    if (frame_single) begin
                        if (frame_code == cand_q) begin
                            if (4'(cnt_q + 4'd1) == DEB) begin
                                accept  = 1'b1;
                                state_d = HELD;
                                cnt_d   = 4'd0;
                            end else begin
                                cnt_d = 4'(cnt_q + 4'd1);
                            end
                        end else begin
                            cand_d = frame_code;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                HELD: begin
                    if (!frame_none) begin
                        cnt_d = 4'd0;
                    end else if (4'(cnt_q + 4'd1) == DEB) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = 4'(cnt_q + 4'd1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // Entry register, digit count and commit delivery
    always_comb begin
        commit_prev_d = commit_btn;
        commit_rise   = commit_btn && !commit_prev_q;
        shifted       = {entry_q[27:0], frame_code};

        entry_d       = entry_q;
        digit_count_d = digit_count_q;
        data_bits_d   = data_bits_q;
        data_valid_d  = commit_rise;
        key_strobe_d  = accept;
        key_code_d    = accept ? frame_code : key_code_q;

        if (commit_rise) begin
            data_bits_d   = accept ? shifted : entry_q;
            entry_d       = 32'd0;
            digit_count_d = 4'd0;
        end else if (accept) begin
            entry_d       = shifted;
            digit_count_d = (digit_count_q >= MAX_DIGITS) ? MAX_DIGITS
                                                          : 4'(digit_count_q + 4'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q         <= '0;
            row_q         <= 2'd0;
            key_row_q     <= 4'b1110;
            acc_n_q       <= 2'd0;
            acc_code_q    <= 4'd0;
            state_q       <= IDLE;
            cand_q        <= 4'd0;
            cnt_q         <= 4'd0;
            entry_q       <= 32'd0;
            digit_count_q <= 4'd0;
            data_bits_q   <= 32'd0;
            data_valid_q  <= 1'b0;
            key_code_q    <= 4'd0;
            key_strobe_q  <= 1'b0;
            commit_prev_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            row_q         <= row_d;
            key_row_q     <= key_row_d;
            acc_n_q       <= acc_n_d;
            acc_code_q    <= acc_code_d;
            state_q       <= state_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            entry_q       <= entry_d;
            digit_count_q <= digit_count_d;
            data_bits_q   <= data_bits_d;
            data_valid_q  <= data_valid_d;
            key_code_q    <= key_code_d;
            key_strobe_q  <= key_strobe_d;
            commit_prev_q <= commit_prev_d;
        end
    end

    assign key_row     = key_row_q;
    assign data_bits   = data_bits_q;
    assign data_valid  = data_valid_q;
    assign key_code    = key_code_q;
    assign key_strobe  = key_strobe_q;
    assign digit_count = digit_count_q;

endmodule
